serial_and4_rx: RTL and testbench
=================================

Name: serial_and4_rx

Overview:
- Serial counterpart of the team's 4-input AND gate.
- Receives a frame of N single bits, one per accepted cycle, over a valid/ready stream.
- Folds each bit into a running AND, then presents the N-input AND result on a valid/ready output.
- Sits between a bit-serial source (shift register / serializer lab block) and any consumer of the reduced flag.

Parameters:
- N, 4, bits per frame; legal range 2..255.
- CNT_W, $clog2(N), width of the bit counter; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous abort; discards the partial frame
- in_valid  input  1  in_bit is valid this cycle
- in_ready  output  1  block accepts in_bit this cycle
- in_bit  input  1  serial data bit
- out_valid  output  1  result is valid
- out_ready  input  1  consumer takes the result this cycle
- out  output  1  AND of the N accepted bits of the frame
- busy  output  1  high when at least one bit of the current frame has been accepted, or a result is pending

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - rst_n low → state ACC, acc=1, cnt=0, in_ready=1, out_valid=0, out=0, busy=0.
- States:
  - ACC: accepting bits.
  - HOLD: result pending.
- ACC:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid & in_ready: acc <= acc & in_bit, cnt <= cnt+1.
  - On the accepted beat with cnt==N-1: out <= acc & in_bit, acc <= 1, cnt <= 0, next state HOLD.
- HOLD:
  - in_ready=0, out_valid=1, out stable.
  - On out_ready: back to ACC. out_valid drops the next cycle; out keeps its last value.
- Latency and throughput:
  - out_valid rises on the cycle after the N-th accepted bit.
  - Peak throughput is one frame per N+1 cycles. There is no overlap of HOLD with the next frame.
- Backpressure:
  - in_valid low in ACC → no state change; gaps are allowed anywhere in a frame.
  - out_ready low in HOLD → hold indefinitely; out and out_valid remain stable.
- clr:
  - In ACC: acc=1, cnt=0. A beat presented in the same cycle is dropped (clr wins).
  - In HOLD: drop the pending result and return to ACC, even if out_ready is high the same cycle.
- busy = (state==HOLD) | (cnt!=0).
- Reset mid-frame or mid-HOLD: immediate return to reset values; no partial result is ever emitted.
- cnt never exceeds N-1; it wraps to 0 only at frame end or on clr.

Optional Feature:
- Macro: SERIAL_AND4_ZERO_CNT_EN.
- Defined:
  - Extra output port zero_cnt, width CNT_W+1: number of zero bits accepted in the frame.
  - Updated and held exactly alongside out.
  - Reset value 0; cleared with clr.
- Undefined: port, register and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package serial_and4_pkg:
  - state enum {ACC, HOLD}.
  - Default frame length constant SERIAL_AND4_N=4.
- Sub-module serial_bit_counter:
  - Parameterised N.
  - Inputs: inc, clr.
  - Output: last (cnt==N-1).
- The AND combine reuses the team's existing two-input AND cell.

Test Plan:
- Reset, then bits 1,1,1,1 on consecutive cycles with out_ready=1 → out_valid=1 for one cycle, out=1, starting one cycle after the 4th beat; in_ready=0 during that cycle.
- Bits 1,0,1,1 with in_valid gaps of 2 idle cycles between beats → out=1'b0; busy high from the 1st beat until the HOLD exit. With ZERO_CNT_EN: zero_cnt=1.
- Frame 1,1,1,1 with out_ready held low 5 cycles → out_valid and out=1 stable for 6 cycles; in_ready=0 throughout; an in_valid beat offered meanwhile is not consumed.
- 2 beats (1,1), then clr together with a 3rd beat, then 1,0,1,1 → only one result, out=0; the dropped beat does not count.
- rst_n pulsed low asynchronously mid-HOLD (between clock edges) → out_valid=0 and in_ready=1 immediately; the next full frame 1,1,1,1 yields out=1.
- Back-to-back frames 1111, 0000, 1111 with out_ready=1 → results 1,0,1 at cycles 5, 10, 15 after the first beat. With ZERO_CNT_EN: zero_cnt=0,4,0.

Source files
------------

// File: rtl/serial_and4_pkg.sv
// Shared types and constants for the serial 4-input AND receiver.
package serial_and4_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int SERIAL_AND4_N = 4;

endpackage

// File: rtl/and2_cell.sv
// Team two-input AND cell, reused as the combine stage of the serial receiver.
module and2_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/serial_bit_counter.sv
// Counts accepted bits of a frame; wraps to zero on the last bit or on clr.
import serial_and4_pkg::*;

module serial_bit_counter #(
  parameter  int N     = SERIAL_AND4_N,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] r_cnt;

  assign last = (r_cnt == CNT_W'(N - 1));
  assign cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_and4_rx.sv
// Bit-serial N-input AND over valid/ready streams.
// Optional zero-bit count output enabled by defining SERIAL_AND4_ZERO_CNT_EN.
import serial_and4_pkg::*;

module serial_and4_rx #(
  parameter  int N     = SERIAL_AND4_N,
  localparam int CNT_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_bit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out,
  output logic           busy
`ifdef SERIAL_AND4_ZERO_CNT_EN
  ,
  output logic [CNT_W:0] zero_cnt
`endif
);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_acc;
  logic             r_out;
  logic             w_accept;
  logic             w_last;
  logic             w_andBit;
  logic [CNT_W-1:0] w_cnt;

  // clr wins over a beat offered in the same cycle
  assign w_accept = in_valid & in_ready & ~clr;

  serial_bit_counter #(.N(N)) u_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (w_accept),
    .clr  (clr),
    .cnt  (w_cnt),
    .last (w_last)
  );

  and2_cell u_and (
    .a(r_acc),
    .b(in_bit),
    .y(w_andBit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACC;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACC: begin
        in_ready = 1'b1;
        if (w_accept && w_last) w_nextState = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (clr || out_ready) w_nextState = ACC;
      end
      default: w_nextState = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 1'b1;
      r_out <= 1'b0;
    end else if (r_state == ACC) begin
      if (clr) begin
        r_acc <= 1'b1;
      end else if (w_accept) begin
        if (w_last) begin
          r_acc <= 1'b1;
          r_out <= w_andBit;
        end else begin
          r_acc <= w_andBit;
        end
      end
    end
  end

  assign out  = r_out;
  assign busy = (r_state == HOLD) | (w_cnt != '0);

`ifdef SERIAL_AND4_ZERO_CNT_EN
  logic [CNT_W:0] r_zeroRun;
  logic [CNT_W:0] r_zeroCnt;
  logic [CNT_W:0] w_zeroNext;

  assign w_zeroNext = r_zeroRun + {{CNT_W{1'b0}}, ~in_bit};

  // Running count is published at frame end, in step with out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zeroRun <= '0;
      r_zeroCnt <= '0;
    end else if (clr) begin
      r_zeroRun <= '0;
      r_zeroCnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_zeroRun <= '0;
        r_zeroCnt <= w_zeroNext;
      end else begin
        r_zeroRun <= w_zeroNext;
      end
    end
  end

  assign zero_cnt = r_zeroCnt;
`endif

endmodule

// File: tb/tb_serial_and4_rx.sv
// Directed self-checking bench for serial_and4_rx (N=4).
module tb_serial_and4_rx;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out;
  logic       busy;
`ifdef SERIAL_AND4_ZERO_CNT_EN
  logic [2:0] zero_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  serial_and4_rx #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
`ifdef SERIAL_AND4_ZERO_CNT_EN
    ,
    .zero_cnt (zero_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic r, input logic c);
    in_valid  = v;
    in_bit    = b;
    out_ready = r;
    clr       = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] expOut;
    logic [2:0] frameBit;
    int         frame;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Frame 1111 with out_ready high
    sendBeat(1'b1);
    checkOutput("t1_busy_first", busy, 1);
    checkOutput("t1_valid_early", out_valid, 0);
    sendBeat(1'b1);
    sendBeat(1'b1);
    checkOutput("t1_valid_beat3", out_valid, 0);
    sendBeat(1'b1);
    checkOutput("t1_out_valid", out_valid, 1);
    checkOutput("t1_out", out, 1);
    checkOutput("t1_in_ready_hold", in_ready, 0);
    tick();
    checkOutput("t1_valid_drop", out_valid, 0);
    checkOutput("t1_out_kept", out, 1);
    checkOutput("t1_busy_idle", busy, 0);
    checkOutput("t1_in_ready_back", in_ready, 1);

    // Frame 1011 with two idle cycles between beats
    sendBeat(1'b1);
    tick();
    tick();
    checkOutput("t2_busy_gap", busy, 1);
    sendBeat(1'b0);
    tick();
    tick();
    sendBeat(1'b1);
    tick();
    tick();
    checkOutput("t2_valid_gap", out_valid, 0);
    sendBeat(1'b1);
    checkOutput("t2_out_valid", out_valid, 1);
    checkOutput("t2_out", out, 0);
    checkOutput("t2_busy_hold", busy, 1);
`ifdef SERIAL_AND4_ZERO_CNT_EN
    checkOutput("t2_zero_cnt", zero_cnt, 1);
`endif
    tick();
    checkOutput("t2_valid_drop", out_valid, 0);
    checkOutput("t2_busy_idle", busy, 0);

    // Frame 1111 held by out_ready low for 5 cycles, beat offered meanwhile
    out_ready = 1'b0;
    sendBeat(1'b1);
    sendBeat(1'b1);
    sendBeat(1'b1);
    sendBeat(1'b1);
    checkOutput("t3_hold_valid0", out_valid, 1);
    in_valid = 1'b1;
    in_bit   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_valid", out_valid, 1);
      checkOutput("t3_hold_out", out, 1);
      checkOutput("t3_hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("t3_release_valid", out_valid, 0);
    checkOutput("t3_not_consumed", busy, 0);

    // Partial frame aborted by clr together with a third beat
    sendBeat(1'b1);
    sendBeat(1'b1);
    clr = 1'b1;
    sendBeat(1'b0);
    clr = 1'b0;
    checkOutput("t4_clr_busy", busy, 0);
    sendBeat(1'b1);
    sendBeat(1'b0);
    checkOutput("t4_valid_b2", out_valid, 0);
    sendBeat(1'b1);
    checkOutput("t4_valid_b3", out_valid, 0);
    sendBeat(1'b1);
    checkOutput("t4_out_valid", out_valid, 1);
    checkOutput("t4_out", out, 0);
`ifdef SERIAL_AND4_ZERO_CNT_EN
    checkOutput("t4_zero_cnt", zero_cnt, 1);
`endif
    tick();
    checkOutput("t4_single_result", out_valid, 0);

    // Asynchronous reset in the middle of HOLD
    out_ready = 1'b0;
    sendBeat(1'b1);
    sendBeat(1'b1);
    sendBeat(1'b1);
    sendBeat(1'b1);
    checkOutput("t5_in_hold", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", out_valid, 0);
    checkOutput("t5_rst_in_ready", in_ready, 1);
    checkOutput("t5_rst_out", out, 0);
    checkOutput("t5_rst_busy", busy, 0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    sendBeat(1'b1);
    sendBeat(1'b1);
    sendBeat(1'b1);
    sendBeat(1'b1);
    checkOutput("t5_after_valid", out_valid, 1);
    checkOutput("t5_after_out", out, 1);
    tick();

    // Back-to-back frames 1111, 0000, 1111 with in_valid held high
    expOut   = 3'b101;
    frameBit = 3'b101;
    in_valid = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      frame  = (k - 1) / 5;
      in_bit = frameBit[frame];
      tick();
      if (k % 5 == 4) begin
        checkOutput("t6_valid", out_valid, 1);
        checkOutput("t6_out", out, expOut[frame]);
`ifdef SERIAL_AND4_ZERO_CNT_EN
        checkOutput("t6_zero_cnt", zero_cnt, (frame == 1) ? 4 : 0);
`endif
      end else begin
        checkOutput("t6_no_valid", out_valid, 0);
      end
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
